// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the memory-access stage.
package mips_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } mau_state_e;

    localparam int TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access sequencer: issues one dmem transaction per load/store,
// stalls the pipeline until it completes, and reports alignment and bus-timeout faults.
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ValidM,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic        StallM,
    output logic [31:0] ReadDataM,
    output logic        AlignErrM,
    output logic        BusErrM,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output mau_state_e  dbg_state
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    // Handshake: dmem_req is held with stable addr/we/wdata until a cycle where
    // dmem_gnt is high; dmem_rvalid is only honoured in WAIT or in the granting REQ cycle of a load.

    mau_state_e       state_q, state_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             we_q, we_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             align_q, align_d;
    logic             bus_q, bus_d;

    logic mem_op;
    logic timeout;

    assign mem_op  = ValidM & (MemReadM | MemWriteM);
    // The cycle whose increment makes the counter reach TIMEOUT_CYC is the last one spent waiting.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        align_d   = align_q;
        bus_d     = bus_q;
        StallM    = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ReadDataM = 32'd0;
        AlignErrM = 1'b0;
        BusErrM   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rdata_d = 32'd0;
                align_d = 1'b0;
                bus_d   = 1'b0;
                if (mem_op) begin
                    StallM = 1'b1;
                    if (ALUOutM[1:0] == 2'b00) begin
                        addr_d  = {ALUOutM[31:2], 2'b00};
                        wdata_d = WriteDataM;
                        we_d    = MemWriteM;
                        cnt_d   = '0;
                        state_d = ST_REQ;
                    end else begin
                        align_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_REQ: begin
                StallM   = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = we_q;
                cnt_d    = cnt_q + CNT_W'(1);
                if (dmem_gnt) begin
                    if (we_q) begin
                        state_d = ST_DONE;
                    end else if (dmem_rvalid) begin
                        rdata_d = dmem_rdata;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (timeout) begin
                    bus_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_DONE;
                end
            end
            ST_WAIT: begin
                StallM = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (dmem_rvalid) begin
                    rdata_d = dmem_rdata;
                    state_d = ST_DONE;
                end else if (timeout) begin
                    bus_d   = 1'b1;
                    rdata_d = 32'd0;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                ReadDataM = rdata_q;
                AlignErrM = align_q;
                BusErrM   = bus_q;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= 32'd0;
            align_q <= 1'b0;
            bus_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            align_q <= align_d;
            bus_q   <= bus_d;
        end
    end

    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter TIMEOUT_CYC, default 255, is the maximum number of cycles spent waiting on dmem before a bus error is raised.
REQ-002 clk  input  1  the only clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 ValidM  input  1  an instruction occupies the MEM stage.
REQ-005 MemReadM / MemWriteM  input  1 each  load / store in MEM; both high together is illegal and SHALL be treated as a store.
REQ-006 ALUOutM  input  32  effective address from the EX result.
REQ-007 WriteDataM  input  32  store data (EX-forwarded rt value).
REQ-008 StallM  output  1  freezes PC, IF/ID, ID/EX and EX/MEM while high.
REQ-009 ReadDataM  output  32  load data, valid in the DONE cycle.
REQ-010 AlignErrM / BusErrM  output  1 each  fault flags, valid in the DONE cycle.
REQ-011 dmem_req, dmem_we  output  1 each  bus request and write enable.
REQ-012 dmem_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-013 dmem_wdata  output  32  store data.
REQ-014 dmem_gnt, dmem_rvalid  input  1 each  request accepted / read data valid.
REQ-015 dmem_rdata  input  32  read data.

Function
REQ-016 The FSM SHALL have four states: IDLE, REQ, WAIT, DONE.
REQ-017 IDLE: when ValidM & (MemReadM | MemWriteM) and ALUOutM[1:0]==0, latch address, wdata and we, then go to REQ; StallM SHALL be 1 in that cycle.
REQ-018 IDLE with a misaligned access (ALUOutM[1:0]!=0): go to DONE with AlignErrM=1 and issue no bus request; StallM SHALL be 1 in that cycle.
REQ-019 IDLE with no memory op: StallM=0 and the state stays IDLE.
REQ-020 REQ: dmem_req=1 with latched values; later changes of ALUOutM or WriteDataM SHALL be ignored.
REQ-021 REQ with dmem_gnt: a store goes to DONE; a load goes to WAIT, or to DONE capturing dmem_rdata if dmem_rvalid is also high in the same cycle.
REQ-022 WAIT: dmem_req=0; on dmem_rvalid, capture dmem_rdata into ReadDataM and go to DONE.
REQ-023 DONE: StallM=0 for exactly one cycle, flags and ReadDataM held valid, then return to IDLE.
REQ-024 A wait counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
REQ-025 When the wait counter reaches TIMEOUT_CYC: go to DONE, BusErrM=1, ReadDataM=0, dmem_req dropped.
REQ-026 StallM SHALL be 1 in REQ and WAIT.
REQ-027 Minimum store latency is 3 cycles (IDLE, REQ, DONE); minimum load latency is 3 cycles with rvalid coincident with gnt, otherwise 4.
REQ-028 dmem_rvalid outside WAIT/REQ-load SHALL be ignored.
REQ-029 ReadDataM SHALL be 0 in DONE for stores and faults.
REQ-030 ReadDataM, AlignErrM and BusErrM are undefined-free: driven 0 in every state except DONE.

Reset
REQ-031 While rst_n=0 at a clock edge, the unit SHALL enter IDLE and clear the counter, latches and ReadDataM.
REQ-032 After that reset edge: StallM=0, dmem_req=0, dmem_we=0, all flags=0.
REQ-033 Reset in REQ or WAIT SHALL abandon the access; a late dmem_rvalid after reset SHALL be ignored.

Structure
REQ-034 The state enum (IDLE/REQ/WAIT/DONE) and the default TIMEOUT_CYC constant SHALL live in the shared mips_pkg package.
REQ-035 No sub-module is needed; the FSM, latches and counter are implemented in one module.

Verification
REQ-036 Store to 0x100 with data 0xDEADBEEF, gnt on the first REQ cycle -> one dmem_req with we=1, addr=0x100, wdata=0xDEADBEEF; StallM high for 2 cycles, low in DONE.
REQ-037 Load from 0x204, gnt at cycle 1, rvalid with 0x12345678 two cycles later -> ReadDataM=0x12345678 in DONE; StallM high in IDLE, REQ and WAIT cycles.
REQ-038 Load to 0x103 -> no dmem_req; AlignErrM=1 and StallM=0 on the second cycle.
REQ-039 Load with gnt held low for 255 cycles -> BusErrM=1, ReadDataM=0, dmem_req drops, StallM releases.
REQ-040 rst_n pulled low in WAIT, then rvalid is asserted -> the unit stays in IDLE, ReadDataM=0, StallM=0.
REQ-041 ALUOutM changed mid-REQ from 0x100 to 0x200 -> dmem_addr stays 0x100 until gnt.
